// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the memory bus arbiter.
// Imported by the arbiter top level.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        RDATA,
        DONE
    } arb_state_t;

    typedef enum logic {
        OWN_IF,
        OWN_D
    } owner_t;

    localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/bus_watchdog.sv
// Counts stalled command cycles and flags when the limit is hit.
// A zero limit disables the watchdog entirely.
module bus_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam bit          ENABLED = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0] LIMIT   =
        ENABLED ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    // Next count: clear wins, otherwise advance on each stalled cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (count_en) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires in the cycle whose stall would make the count reach the limit.
    assign expired = ENABLED && count_en && (cnt_q == LIMIT);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one Avalon-MM master port between fetch and data requesters.
// Data has priority; fetch is forced after STARVE_MAX data grants.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int unsigned STARVE_MAX     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_wdata,
    output logic        d_done,
    output logic [31:0] d_rdata,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [3:0]  avm_byteenable,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        timeout_err
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    arb_state_t  state_q,  state_d;
    owner_t      owner_q,  owner_d;
    logic        we_q,     we_d;
    logic [31:0] addr_q,   addr_d;
    logic [3:0]  be_q,     be_d;
    logic [31:0] wdata_q,  wdata_d;
    logic [31:0] rdata_q,  rdata_d;
    logic [3:0]  starve_q, starve_d;
    logic        terr_q,   terr_d;

    logic grant_if;
    logic grant_d;
    logic wd_clear;
    logic wd_count;
    logic wd_expired;
    logic unused_addr_lsbs;

    assign unused_addr_lsbs = ^{if_addr[1:0], d_addr[1:0]};

    assign grant_if = if_req && (!d_req || (starve_q == STARVE_LIM));
    assign grant_d  = d_req && !grant_if;

    assign wd_clear = (state_q != CMD);
    assign wd_count = (state_q == CMD) && avm_waitrequest;

    bus_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (wd_clear),
        .count_en(wd_count),
        .expired (wd_expired)
    );

    // Next-state: grant and latch in IDLE, then walk the bus phases.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        we_d     = we_q;
        addr_d   = addr_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        starve_d = starve_q;
        terr_d   = terr_q;
        unique case (state_q)
            IDLE: begin
                if (grant_if) begin
                    owner_d  = OWN_IF;
                    we_d     = 1'b0;
                    addr_d   = {if_addr[31:2], 2'b00};
                    be_d     = BE_WORD;
                    wdata_d  = '0;
                    starve_d = '0;
                    state_d  = CMD;
                end else if (grant_d) begin
                    owner_d  = OWN_D;
                    we_d     = d_we;
                    addr_d   = {d_addr[31:2], 2'b00};
                    be_d     = d_be;
                    wdata_d  = d_wdata;
                    starve_d = if_req ? starve_q + 4'd1 : 4'd0;
                    state_d  = CMD;
                end
            end
            CMD: begin
                if (!avm_waitrequest) begin
                    state_d = we_q ? DONE : RDATA;
                end else if (wd_expired) begin
                    terr_d  = 1'b1;
                    rdata_d = '0;
                    state_d = DONE;
                end
            end
            RDATA: begin
                rdata_d = avm_readdata;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and latched transaction registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            owner_q  <= OWN_IF;
            we_q     <= 1'b0;
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            starve_q <= '0;
            terr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            starve_q <= starve_d;
            terr_q   <= terr_d;
        end
    end

    assign avm_read       = (state_q == CMD) && !we_q;
    assign avm_write      = (state_q == CMD) && we_q;
    assign avm_address    = addr_q;
    assign avm_byteenable = be_q;
    assign avm_writedata  = wdata_q;

    assign if_done  = (state_q == DONE) && (owner_q == OWN_IF);
    assign d_done   = (state_q == DONE) && (owner_q == OWN_D);
    assign if_rdata = rdata_q;
    assign d_rdata  = rdata_q;

    assign busy        = (state_q != IDLE);
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter.
// Inputs change and outputs are sampled on the falling edge.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_done;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [3:0]  d_be = '0;
    logic [31:0] d_wdata = '0;
    logic        d_done;
    logic [31:0] d_rdata;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata = '0;
    logic        avm_waitrequest = 1'b0;
    logic        busy;
    logic        timeout_err;

    int total = 0;
    int bad = 0;

    logic exp_is_d [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .STARVE_MAX    (4),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .if_req         (if_req),
        .if_addr        (if_addr),
        .if_done        (if_done),
        .if_rdata       (if_rdata),
        .d_req          (d_req),
        .d_we           (d_we),
        .d_addr         (d_addr),
        .d_be           (d_be),
        .d_wdata        (d_wdata),
        .d_done         (d_done),
        .d_rdata        (d_rdata),
        .avm_address    (avm_address),
        .avm_read       (avm_read),
        .avm_write      (avm_write),
        .avm_byteenable (avm_byteenable),
        .avm_writedata  (avm_writedata),
        .avm_readdata   (avm_readdata),
        .avm_waitrequest(avm_waitrequest),
        .busy           (busy),
        .timeout_err    (timeout_err)
    );

    function automatic logic [137:0] all_outs();
        return {if_done, if_rdata, d_done, d_rdata,
                avm_address, avm_read, avm_write,
                avm_byteenable, avm_writedata,
                busy, timeout_err};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (all_outs() !== '0) begin
            bad++;
            $display("FAIL reset_outs got=%h want=0", all_outs());
        end
        reset = 1'b0;
    endtask

    task automatic test_fetch(input logic [31:0] addr,
                              input logic [31:0] exp_addr,
                              input logic [31:0] data);
        logic [38:0] got;
        if_req = 1'b1;
        if_addr = addr;
        avm_readdata = data;
        avm_waitrequest = 1'b0;
        @(negedge clk);
        got = {avm_read, avm_write, avm_byteenable,
               avm_address, busy};
        total++;
        if (got !== {1'b1, 1'b0, 4'hF, exp_addr, 1'b1}) begin
            bad++;
            $display("FAIL fetch_cmd got=%h want=%h", got,
                     {1'b1, 1'b0, 4'hF, exp_addr, 1'b1});
        end
        if_req = 1'b0;
        if_addr = '0;
        @(negedge clk);
        total++;
        if ({avm_read, avm_write, if_done, busy} !== 4'b0001) begin
            bad++;
            $display("FAIL fetch_rdata got=%b want=0001",
                     {avm_read, avm_write, if_done, busy});
        end
        @(negedge clk);
        avm_readdata = '0;
        total++;
        if ({if_done, d_done, if_rdata} !== {2'b10, data}) begin
            bad++;
            $display("FAIL fetch_done got=%b/%b/%h want=1/0/%h",
                     if_done, d_done, if_rdata, data);
        end
        @(negedge clk);
        total++;
        if ({if_done, busy} !== 2'b00) begin
            bad++;
            $display("FAIL fetch_idle got=%b want=00",
                     {if_done, busy});
        end
    endtask

    task automatic test_store_stall();
        logic [69:0] got;
        logic [69:0] want;
        want = {1'b1, 1'b0, 32'h0000_1004, 4'b0100, 32'h00AB_0000};
        d_req = 1'b1;
        d_we = 1'b1;
        d_addr = 32'h0000_1004;
        d_be = 4'b0100;
        d_wdata = 32'h00AB_0000;
        avm_waitrequest = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            d_req = 1'b0;
            d_wdata = '0;
            got = {avm_write, avm_read, avm_address,
                   avm_byteenable, avm_writedata};
            total++;
            if (got !== want || if_done !== 1'b0) begin
                bad++;
                $display("FAIL store_cmd%0d got=%h/%b want=%h/0",
                         i, got, if_done, want);
            end
            avm_waitrequest = (i < 3);
        end
        @(negedge clk);
        total++;
        if ({d_done, if_done, avm_write} !== 3'b100) begin
            bad++;
            $display("FAIL store_done got=%b want=100",
                     {d_done, if_done, avm_write});
        end
        @(negedge clk);
        total++;
        if ({d_done, if_done, busy} !== 3'b000) begin
            bad++;
            $display("FAIL store_idle got=%b want=000",
                     {d_done, if_done, busy});
        end
        d_we = 1'b0;
    endtask

    task automatic test_priority();
        int n;
        bit both;
        n = 0;
        both = 1'b0;
        d_req = 1'b1;
        d_we = 1'b0;
        d_addr = 32'h0000_0200;
        d_be = 4'hF;
        if_req = 1'b1;
        if_addr = 32'h0000_0100;
        avm_readdata = 32'hDEAD_BEEF;
        avm_waitrequest = 1'b0;
        for (int c = 0; c < 60 && n < 6; c++) begin
            @(negedge clk);
            if (avm_read && avm_write) both = 1'b1;
            if (if_done || d_done) begin
                total++;
                if ({d_done, if_done} !== {exp_is_d[n], !exp_is_d[n]})
                begin
                    bad++;
                    $display("FAIL prio_grant%0d got d=%b if=%b want d=%b",
                             n, d_done, if_done, exp_is_d[n]);
                end
                n++;
            end
        end
        d_req = 1'b0;
        if_req = 1'b0;
        total++;
        if (n != 6) begin
            bad++;
            $display("FAIL prio_count got=%0d want=6", n);
        end
        total++;
        if (both) begin
            bad++;
            $display("FAIL prio_strobes got=both want=exclusive");
        end
        repeat (2) @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL prio_idle got=%b want=0", busy);
        end
    endtask

    task automatic test_watchdog();
        int rcyc;
        rcyc = 0;
        d_req = 1'b1;
        d_we = 1'b0;
        d_addr = 32'h0000_2000;
        d_be = 4'hF;
        avm_readdata = 32'h5555_5555;
        avm_waitrequest = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            d_req = 1'b0;
            if (!avm_read) break;
            rcyc++;
        end
        total++;
        if (rcyc != 8) begin
            bad++;
            $display("FAIL wd_cycles got=%0d want=8", rcyc);
        end
        total++;
        if ({d_done, if_done, timeout_err, d_rdata} !==
            {3'b101, 32'h0}) begin
            bad++;
            $display("FAIL wd_done got=%b/%b/%b/%h want=1/0/1/0",
                     d_done, if_done, timeout_err, d_rdata);
        end
        avm_waitrequest = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({timeout_err, busy, d_done} !== 3'b100) begin
            bad++;
            $display("FAIL wd_sticky got=%b want=100",
                     {timeout_err, busy, d_done});
        end
    endtask

    task automatic test_reset_mid_read();
        if_req = 1'b1;
        if_addr = 32'h0000_0040;
        avm_readdata = 32'h1111_1111;
        avm_waitrequest = 1'b0;
        @(negedge clk);
        if_req = 1'b0;
        total++;
        if (avm_read !== 1'b1) begin
            bad++;
            $display("FAIL rst_cmd got=%b want=1", avm_read);
        end
        @(negedge clk);
        total++;
        if ({busy, avm_read} !== 2'b10) begin
            bad++;
            $display("FAIL rst_rdata got=%b want=10",
                     {busy, avm_read});
        end
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (all_outs() !== '0) begin
            bad++;
            $display("FAIL rst_mid got=%h want=0", all_outs());
        end
        reset = 1'b0;
        avm_readdata = '0;
        @(negedge clk);
        total++;
        if ({if_done, d_done, busy} !== 3'b000) begin
            bad++;
            $display("FAIL rst_after got=%b want=000",
                     {if_done, d_done, busy});
        end
        test_fetch(32'h0000_0087, 32'h0000_0084, 32'h1234_5678);
    endtask

    initial begin
        test_reset();
        test_fetch(32'hBFC0_0002, 32'hBFC0_0000, 32'h2402_0005);
        test_store_stall();
        test_priority();
        test_watchdog();
        test_reset_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
